// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Main-memory model behind the instruction and data caches. It owns the
//   memory side of the mem_req/mem_resp handshake and serves one transaction
//   at a time:
//   - A read returns a line-aligned burst of BEATS beats, in ascending order.
//     Beat 0 is valid READ_LATENCY cycles after the request is accepted.
//   - A write commits one beat under a byte mask.
//   Storage is never cleared by reset.
//
// Ports
//   clk                    clock
//   reset                  synchronous, active-high reset
//   i_mem_req_valid        request address/rw valid
//   o_mem_req_ready        responder can accept a request (IDLE only)
//   i_mem_req_addr         beat address; bits above DEPTH_LOG2 alias
//   i_mem_req_rw           1 = write, 0 = read
//   i_mem_req_data_valid   write data valid
//   o_mem_req_data_ready   responder can accept write data
//   i_mem_req_data_bits    write data
//   i_mem_req_data_mask    byte enables; bit i covers bits [8i+7:8i]
//   o_mem_resp_valid       read beat valid (no back-pressure)
//   o_mem_resp_data        read beat data, held outside a burst
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_BITS    = 28,
   parameter int DATA_BITS    = 128,
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = 4,
   parameter int BEATS        = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_mem_req_valid,
   output logic                   o_mem_req_ready,
   input  logic [ADDR_BITS-1:0]   i_mem_req_addr,
   input  logic                   i_mem_req_rw,
   input  logic                   i_mem_req_data_valid,
   output logic                   o_mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   i_mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] i_mem_req_data_mask,
   output logic                   o_mem_resp_valid,
   output logic [DATA_BITS-1:0]   o_mem_resp_data
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [DEPTH_LOG2-1:0] LINE_MASK = ~(DEPTH_LOG2'(BEATS - 1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      WAIT  = 2'd2,
      BURST = 2'd3
   } state_t;

   // Beat k of the line containing address a.
   // The low address bits are replaced by k, so bursts always run in ascending order.
   function automatic logic [DEPTH_LOG2-1:0] beat_idx(input logic [DEPTH_LOG2-1:0] a,
                                                      input logic [BEAT_W-1:0]     k);
      return (a & LINE_MASK) | DEPTH_LOG2'(k);
   endfunction

   logic [DATA_BITS-1:0]  r_mem [0:DEPTH-1];
   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_addr;
   logic [DEPTH_LOG2-1:0] w_addr_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [BEAT_W-1:0]     w_beat_nxt;
   logic                  r_resp_valid;
   logic                  w_resp_valid_nxt;
   logic [DATA_BITS-1:0]  r_resp_data;
   logic                  w_rd_en;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic                  w_wr_en;
   logic [DEPTH_LOG2-1:0] w_wr_idx;
   logic [DEPTH_LOG2-1:0] w_req_idx;
   logic                  w_unused_addr_hi;

   // Only the low DEPTH_LOG2 address bits select a beat; the upper bits alias.
   assign w_req_idx        = i_mem_req_addr[DEPTH_LOG2-1:0];
   assign w_unused_addr_hi = ^i_mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

   assign o_mem_req_ready      = (r_state == IDLE);
   assign o_mem_req_data_ready = (r_state == WDATA) ||
                                 ((r_state == IDLE) && i_mem_req_valid && i_mem_req_rw);
   assign o_mem_resp_valid     = r_resp_valid;
   assign o_mem_resp_data      = r_resp_data;

   // Next state, counters, and the memory read/write controls.
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_cnt_nxt        = r_cnt;
      w_beat_nxt       = r_beat;
      w_resp_valid_nxt = 1'b0;
      w_rd_en          = 1'b0;
      w_rd_idx         = beat_idx(r_addr, BEAT_W'(0));
      w_wr_en          = 1'b0;
      w_wr_idx         = r_addr;
      case (r_state)
         IDLE: begin
            if (i_mem_req_valid) begin
               w_addr_nxt = w_req_idx;
               if (i_mem_req_rw) begin
                  if (i_mem_req_data_valid) begin
                     // Write with data in the same cycle commits here; stay idle.
                     w_wr_en  = 1'b1;
                     w_wr_idx = w_req_idx;
                  end else begin
                     w_state_nxt = WDATA;
                  end
               end else if (READ_LATENCY == 1) begin
                  // Latency 1 skips WAIT: beat 0 is fetched at the acceptance edge.
                  w_state_nxt      = BURST;
                  w_rd_en          = 1'b1;
                  w_rd_idx         = beat_idx(w_req_idx, BEAT_W'(0));
                  w_resp_valid_nxt = 1'b1;
                  w_beat_nxt       = BEAT_W'(0);
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_W'(READ_LATENCY - 1);
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WDATA: begin
            if (i_mem_req_data_valid) begin
               w_wr_en     = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WDATA;
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            // The counter reaches 0 at this edge, so beat 0 is fetched
            // for the first BURST cycle.
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt      = BURST;
               w_cnt_nxt        = CNT_W'(0);
               w_rd_en          = 1'b1;
               w_rd_idx         = beat_idx(r_addr, BEAT_W'(0));
               w_resp_valid_nxt = 1'b1;
               w_beat_nxt       = BEAT_W'(0);
            end else begin
               w_state_nxt = WAIT;
            end
         end
         BURST: begin
            if (r_beat == BEAT_W'(BEATS - 1)) begin
               w_state_nxt = IDLE;
               w_beat_nxt  = BEAT_W'(0);
            end else begin
               w_beat_nxt       = r_beat + BEAT_W'(1);
               w_rd_en          = 1'b1;
               w_rd_idx         = beat_idx(r_addr, r_beat + BEAT_W'(1));
               w_resp_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control state, counters, and response valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_beat       <= '0;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_beat       <= w_beat_nxt;
         r_resp_valid <= w_resp_valid_nxt;
      end
   end

   // Response data register.
   // It loads only for burst beats, so it holds its value between bursts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_data <= '0;
      end else if (w_rd_en) begin
         r_resp_data <= r_mem[w_rd_idx];
      end else begin
         r_resp_data <= r_resp_data;
      end
   end

   // Byte-masked storage write.
   // Storage itself is never reset; a write in flight at a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) begin
         for (int i = 0; i < DATA_BITS / 8; i++) begin
            if (i_mem_req_data_mask[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= i_mem_req_data_bits[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [27:0]  req_addr;
   logic         req_rw;
   logic         data_valid;
   logic         data_ready;
   logic [127:0] data_bits;
   logic [15:0]  data_mask;
   logic         resp_valid;
   logic [127:0] resp_data;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [127:0] rd_beats [4];
   int           rd_lat;

   localparam logic [127:0] D1   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] B11  = 128'h11111111111111111111111111111111;
   localparam logic [127:0] B12  = 128'h12121212121212121212121212121212;
   localparam logic [127:0] B13  = 128'h13131313131313131313131313131313;
   localparam logic [127:0] P55  = 128'h55555555555555555555555555555555;
   localparam logic [127:0] PAA  = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
   localparam logic [127:0] EXP2 = 128'h555555555555555555555555AAAAAAAA;
   localparam logic [127:0] W40  = 128'h40404040404040404040404040404040;
   localparam logic [127:0] JUNK = 128'hFFFFFFFF00000000FFFFFFFF00000000;
   localparam logic [127:0] WNEW = 128'hCAFEBABECAFEBABECAFEBABECAFEBABE;
   localparam logic [127:0] DEAD = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

   mem_responder dut (
      .clk                  (clk),
      .reset                (reset),
      .i_mem_req_valid      (req_valid),
      .o_mem_req_ready      (req_ready),
      .i_mem_req_addr       (req_addr),
      .i_mem_req_rw         (req_rw),
      .i_mem_req_data_valid (data_valid),
      .o_mem_req_data_ready (data_ready),
      .i_mem_req_data_bits  (data_bits),
      .i_mem_req_data_mask  (data_mask),
      .o_mem_resp_valid     (resp_valid),
      .o_mem_resp_data      (resp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
      req_valid  = 1'b1;
      req_rw     = 1'b1;
      req_addr   = a;
      data_valid = 1'b1;
      data_bits  = d;
      data_mask  = m;
      chk("wr_ready", req_ready, 1'b1);
      tick();
      req_valid  = 1'b0;
      req_rw     = 1'b0;
      data_valid = 1'b0;
   endtask

   task automatic issue_read(input logic [27:0] a);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = a;
      chk("rd_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
   endtask

   // Called right after the acceptance edge. Records the latency in cycles
   // from acceptance and captures the four beats. Returns in the cycle after
   // the last beat.
   task automatic collect_burst();
      int n;
      n = 1;
      while (!resp_valid && n < 20) begin
         tick();
         n++;
      end
      rd_lat = n;
      if (!resp_valid) chk("burst_timeout", 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         rd_beats[k] = resp_data;
         chk("burst_valid", resp_valid, 1'b1);
         tick();
      end
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 28'h0;
      req_rw     = 1'b0;
      data_valid = 1'b0;
      data_bits  = 128'h0;
      data_mask  = 16'h0;
      tick();
      tick();
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_data", resp_data, 128'h0);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_data_ready", data_ready, 1'b0);
      reset = 1'b0;
      tick();

      // 1: full write with same-cycle data, then read it back.
      do_write(28'h11, B11, 16'hFFFF);
      do_write(28'h12, B12, 16'hFFFF);
      do_write(28'h13, B13, 16'hFFFF);
      do_write(28'h10, D1, 16'hFFFF);
      issue_read(28'h10);
      collect_burst();
      chk("t1_latency", rd_lat, 4);
      chk("t1_beat0", rd_beats[0], D1);
      chk("t1_beat1", rd_beats[1], B11);
      chk("t1_beat2", rd_beats[2], B12);
      chk("t1_beat3", rd_beats[3], B13);
      chk("t1_valid_after", resp_valid, 1'b0);
      chk("t1_data_held", resp_data, B13);
      chk("t1_ready_after", req_ready, 1'b1);

      // 2: partial write over all-0x55 contents.
      for (int i = 0; i < 4; i++) do_write(28'h20 + 28'(i), P55, 16'hFFFF);
      do_write(28'h21, PAA, 16'h000F);
      issue_read(28'h20);
      collect_burst();
      chk("t2_beat0", rd_beats[0], P55);
      chk("t2_beat1", rd_beats[1], EXP2);
      chk("t2_beat2", rd_beats[2], P55);
      chk("t2_beat3", rd_beats[3], P55);

      // 3: write data arrives 3 cycles after the request.
      do_write(28'h40, W40, 16'hFFFF);
      req_valid  = 1'b1;
      req_rw     = 1'b1;
      req_addr   = 28'h40;
      data_valid = 1'b0;
      data_bits  = JUNK;
      data_mask  = 16'hFFFF;
      chk("t3_dready_idle", data_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_ready_wdata", req_ready, 1'b0);
         chk("t3_dready_wdata", data_ready, 1'b1);
         tick();
      end
      data_valid = 1'b1;
      data_bits  = WNEW;
      tick();
      data_valid = 1'b0;
      chk("t3_ready_back", req_ready, 1'b1);
      chk("t3_dready_off", data_ready, 1'b0);
      issue_read(28'h40);
      collect_burst();
      chk("t3_beat0", rd_beats[0], WNEW);

      // 4: unaligned read, and a request held through the burst.
      for (int i = 0; i < 4; i++) do_write(28'h30 + 28'(i), {4{24'h0, 8'(8'h30 + i)}}, 16'hFFFF);
      issue_read(28'h33);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 28'h10;
      chk("t4_ready_busy", req_ready, 1'b0);
      collect_burst();
      chk("t4_latency", rd_lat, 4);
      for (int k = 0; k < 4; k++) chk("t4_beat", rd_beats[k], {4{24'h0, 8'(8'h30 + k)}});
      chk("t4_valid_after", resp_valid, 1'b0);
      chk("t4_ready_next", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      collect_burst();
      chk("t4_b2b_latency", rd_lat, 4);
      chk("t4_b2b_beat0", rd_beats[0], D1);

      // 5: reset asserted during the second beat.
      issue_read(28'h30);
      for (int i = 0; i < 20 && !resp_valid; i++) tick();
      chk("t5_beat0_valid", resp_valid, 1'b1);
      tick();
      chk("t5_beat1_valid", resp_valid, 1'b1);
      reset = 1'b1;
      tick();
      chk("t5_valid_reset", resp_valid, 1'b0);
      chk("t5_data_reset", resp_data, 128'h0);
      chk("t5_ready_reset", req_ready, 1'b1);
      reset = 1'b0;
      tick();
      issue_read(28'h10);
      collect_burst();
      chk("t5_survive", rd_beats[0], D1);

      // 6: address aliasing above DEPTH_LOG2.
      do_write(28'h1000, DEAD, 16'hFFFF);
      issue_read(28'h0);
      collect_burst();
      chk("t6_alias", rd_beats[0], DEAD);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
